// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered decode stage for the OLED/I2C sequencer core. It sits between
//   instruction fetch and the execute/I2C engine. It splits instructions into
//   control fields behind a valid/ready handshake. A scoreboard of pending
//   register writes stalls read-after-write hazards until writeback. A branch
//   flush drops the held instruction.
//
//   Instruction layout (MSB first):
//     opcode [OPC_W] | dest [REG_W] | src [REG_W] | reserved | imm [IMM_W]
//
//   Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//     When it is defined, opcodes D-F raise o_illegal and latch a trap. The
//     trap holds o_ready low until i_flush or reset clears it. When it is
//     undefined, D-F decode as NOP and o_illegal is tied low.
module instr_decode_stage #(
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 8,
    parameter int INSTR_W = 21
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_valid,
    input  logic               i_ready,
    input  logic               i_flush,
    input  logic               i_wb_valid,
    input  logic [REG_W-1:0]   i_wb_dest,
    output logic [REG_W-1:0]   o_dest,
    output logic [REG_W-1:0]   o_src,
    output logic [IMM_W-1:0]   o_imm,
    output logic [IMM_W-1:0]   o_addr,
    output logic [2:0]         o_alu_ctrl,
    output logic               o_rd_wen,
    output logic [2:0]         o_i2c_ctrl,
    output logic [1:0]         o_br_ctrl,
    output logic               o_flag_set,
    output logic               o_illegal
);

    localparam int NREG  = 2 ** REG_W;
    localparam int RSV_W = INSTR_W - OPC_W - 2 * REG_W - IMM_W;

    localparam logic [OPC_W-1:0] OP_ADD      = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OP_SUB      = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_ADDI     = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_I2CSTART = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_I2CSTOP  = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_LOAD     = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_SENDCON  = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_SENDI2C  = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_SETFLAG  = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_BEQ      = OPC_W'(4'h9);
    localparam logic [OPC_W-1:0] OP_BEQF     = OPC_W'(4'hA);
    localparam logic [OPC_W-1:0] OP_JMP      = OPC_W'(4'hB);
    localparam logic [OPC_W-1:0] OP_NOP      = OPC_W'(4'hC);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [OPC_W-1:0] opc_s;
    logic [REG_W-1:0] dest_s;
    logic [REG_W-1:0] src_s;
    logic [IMM_W-1:0] imm_s;

    assign opc_s  = i_instr[INSTR_W-1 -: OPC_W];
    assign dest_s = i_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign src_s  = i_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign imm_s  = i_instr[IMM_W-1:0];

    // The reserved bits carry no meaning; they are folded away here.
    generate
        if (RSV_W > 0) begin : g_rsv
            logic unused_rsv_s;
            assign unused_rsv_s = ^i_instr[IMM_W +: RSV_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             valid_q,    valid_d;
    logic [REG_W-1:0] dest_q,     dest_d;
    logic [REG_W-1:0] src_q,      src_d;
    logic [IMM_W-1:0] imm_q,      imm_d;
    logic [IMM_W-1:0] addr_q,     addr_d;
    logic [2:0]       alu_q,      alu_d;
    logic             wen_q,      wen_d;
    logic [2:0]       i2c_q,      i2c_d;
    logic [1:0]       br_q,       br_d;
    logic             flag_q,     flag_d;
    logic [NREG-1:0]  sb_q,       sb_d;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [2:0]       dec_alu_s;
    logic             dec_wen_s;
    logic [2:0]       dec_i2c_s;
    logic [1:0]       dec_br_s;
    logic             dec_flag_s;
    logic [IMM_W-1:0] dec_imm_s;
    logic [IMM_W-1:0] dec_addr_s;
    logic             rd_dest_s;
    logic             rd_src_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             dec_illegal_s;
`endif

    // Opcode decode: control fields plus which operand registers are read
    always_comb begin
        dec_alu_s  = 3'b000;
        dec_wen_s  = 1'b0;
        dec_i2c_s  = 3'b000;
        dec_br_s   = 2'b00;
        dec_flag_s = 1'b0;
        dec_imm_s  = {IMM_W{1'b0}};
        dec_addr_s = {IMM_W{1'b0}};
        rd_dest_s  = 1'b0;
        rd_src_s   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_illegal_s = 1'b0;
`endif
        case (opc_s)
            OP_ADD: begin
                dec_alu_s = 3'b001;
                dec_wen_s = 1'b1;
                rd_dest_s = 1'b1;
                rd_src_s  = 1'b1;
            end
            OP_SUB: begin
                dec_alu_s = 3'b010;
                dec_wen_s = 1'b1;
                rd_dest_s = 1'b1;
                rd_src_s  = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_s = 3'b001;
                dec_wen_s = 1'b1;
                dec_imm_s = imm_s;
                rd_dest_s = 1'b1;
            end
            OP_I2CSTART: begin
                dec_i2c_s = 3'b001;
            end
            OP_I2CSTOP: begin
                dec_i2c_s = 3'b010;
            end
            OP_LOAD: begin
                dec_alu_s = 3'b011;
                dec_wen_s = 1'b1;
                dec_imm_s = imm_s;
            end
            OP_SENDCON: begin
                dec_i2c_s = 3'b011;
                dec_imm_s = imm_s;
            end
            OP_SENDI2C: begin
                dec_i2c_s = 3'b100;
                rd_src_s  = 1'b1;
            end
            OP_SETFLAG: begin
                dec_flag_s = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_s  = 3'b100;
                dec_br_s   = 2'b01;
                dec_addr_s = imm_s;
                rd_dest_s  = 1'b1;
                rd_src_s   = 1'b1;
            end
            OP_BEQF: begin
                dec_br_s   = 2'b10;
                dec_addr_s = imm_s;
            end
            OP_JMP: begin
                dec_br_s   = 2'b11;
                dec_addr_s = imm_s;
            end
            OP_NOP: begin
                dec_alu_s = 3'b000;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_illegal_s = 1'b1;
`else
                dec_alu_s = 3'b000;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic held_wr_s;
    logic haz_dest_s;
    logic haz_src_s;
    logic hazard_s;
    logic trap_s;
    logic ready_s;
    logic accept_s;
    logic issue_s;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign trap_s    = illegal_q;
    assign o_illegal = illegal_q;
`else
    assign trap_s    = 1'b0;
    assign o_illegal = 1'b0;
`endif

    // A held write-enabled instruction is not yet on the scoreboard, so its
    // destination is compared directly. Writebacks only reach the hazard
    // logic through the registered scoreboard (no same-cycle bypass).
    assign held_wr_s  = valid_q & wen_q;
    assign haz_dest_s = rd_dest_s & (sb_q[dest_s] | (held_wr_s & (dest_q == dest_s)));
    assign haz_src_s  = rd_src_s  & (sb_q[src_s]  | (held_wr_s & (dest_q == src_s)));
    assign hazard_s   = haz_dest_s | haz_src_s;

    assign ready_s  = ~hazard_s & ~i_flush & ~trap_s & (~valid_q | i_ready);
    assign accept_s = i_valid & ready_s;
    assign issue_s  = valid_q & i_ready;
    assign o_ready  = ready_s;

    // Output register next state: a flush drops the held instruction, an
    // accept loads a new one, a downstream handshake empties the stage
    always_comb begin
        valid_d = valid_q;
        dest_d  = dest_q;
        src_d   = src_q;
        imm_d   = imm_q;
        addr_d  = addr_q;
        alu_d   = alu_q;
        wen_d   = wen_q;
        i2c_d   = i2c_q;
        br_d    = br_q;
        flag_d  = flag_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        if (i_flush) begin
            valid_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else if (accept_s) begin
            valid_d = 1'b1;
            dest_d  = dest_s;
            src_d   = src_s;
            imm_d   = dec_imm_s;
            addr_d  = dec_addr_s;
            alu_d   = dec_alu_s;
            wen_d   = dec_wen_s;
            i2c_d   = dec_i2c_s;
            br_d    = dec_br_s;
            flag_d  = dec_flag_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d = dec_illegal_s;
`endif
        end else if (issue_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Scoreboard next state: writeback clears first so that an issuing
    // write to the same register in the same cycle wins
    always_comb begin
        sb_d = sb_q;
        if (i_wb_valid) begin
            sb_d[i_wb_dest] = 1'b0;
        end else begin
            sb_d = sb_q;
        end
        if (issue_s & wen_q) begin
            sb_d[dest_q] = 1'b1;
        end else begin
            sb_d = sb_d;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            dest_q  <= {REG_W{1'b0}};
            src_q   <= {REG_W{1'b0}};
            imm_q   <= {IMM_W{1'b0}};
            addr_q  <= {IMM_W{1'b0}};
            alu_q   <= 3'b000;
            wen_q   <= 1'b0;
            i2c_q   <= 3'b000;
            br_q    <= 2'b00;
            flag_q  <= 1'b0;
            sb_q    <= {NREG{1'b0}};
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            alu_q   <= alu_d;
            wen_q   <= wen_d;
            i2c_q   <= i2c_d;
            br_q    <= br_d;
            flag_q  <= flag_d;
            sb_q    <= sb_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign o_valid    = valid_q;
    assign o_dest     = dest_q;
    assign o_src      = src_q;
    assign o_imm      = imm_q;
    assign o_addr     = addr_q;
    assign o_alu_ctrl = alu_q;
    assign o_rd_wen   = wen_q;
    assign o_i2c_ctrl = i2c_q;
    assign o_br_ctrl  = br_q;
    assign o_flag_set = flag_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage (default parameters). It uses table-driven
// per-cycle vectors plus hand-written sequences for reset and illegal opcodes.
module tb_instr_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [20:0] instr;
    logic        in_valid;
    logic        o_ready;
    logic        o_valid;
    logic        in_ready;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [3:0]  o_dest;
    logic [3:0]  o_src;
    logic [7:0]  o_imm;
    logic [7:0]  o_addr;
    logic [2:0]  o_alu_ctrl;
    logic        o_rd_wen;
    logic [2:0]  o_i2c_ctrl;
    logic [1:0]  o_br_ctrl;
    logic        o_flag_set;
    logic        o_illegal;

    int n_chk;
    int n_fail;

    instr_decode_stage #(
        .OPC_W(4), .REG_W(4), .IMM_W(8), .INSTR_W(21)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_instr    (instr),
        .i_valid    (in_valid),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .i_ready    (in_ready),
        .i_flush    (flush),
        .i_wb_valid (wb_valid),
        .i_wb_dest  (wb_dest),
        .o_dest     (o_dest),
        .o_src      (o_src),
        .o_imm      (o_imm),
        .o_addr     (o_addr),
        .o_alu_ctrl (o_alu_ctrl),
        .o_rd_wen   (o_rd_wen),
        .o_i2c_ctrl (o_i2c_ctrl),
        .o_br_ctrl  (o_br_ctrl),
        .o_flag_set (o_flag_set),
        .o_illegal  (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] instr;
        logic        v;
        logic        ir;
        logic        fl;
        logic        wbv;
        logic [3:0]  wbd;
        logic        rdy;
        logic [35:0] outs;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s, input logic [7:0] imm);
        return {op, d, s, 1'b0, imm};
    endfunction

    // Expected packed outputs: {valid,dest,src,imm,addr,alu,wen,i2c,br,flag,illegal}
    function automatic logic [35:0] eo(input logic v, input logic [3:0] d, input logic [3:0] s,
                                       input logic [7:0] imm, input logic [7:0] addr,
                                       input logic [2:0] alu, input logic wen,
                                       input logic [2:0] i2c, input logic [1:0] br,
                                       input logic flag);
        return {v, d, s, imm, addr, alu, wen, i2c, br, flag, 1'b0};
    endfunction

    function automatic logic [35:0] act_outs();
        return {o_valid, o_dest, o_src, o_imm, o_addr, o_alu_ctrl, o_rd_wen,
                o_i2c_ctrl, o_br_ctrl, o_flag_set, o_illegal};
    endfunction

    task automatic add(input logic [20:0] i, input logic v, input logic ir, input logic fl,
                       input logic wbv, input logic [3:0] wbd, input logic rdy,
                       input logic [35:0] outs);
        vec_t e;
        e.instr = i; e.v = v; e.ir = ir; e.fl = fl;
        e.wbv = wbv; e.wbd = wbd; e.rdy = rdy; e.outs = outs;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [20:0] i, input logic v, input logic ir, input logic fl,
                         input logic wbv, input logic [3:0] wbd);
        instr = i; in_valid = v; in_ready = ir; flush = fl; wb_valid = wbv; wb_dest = wbd;
    endtask

    logic [35:0] zero_outs;
    logic [35:0] exp_s;

    initial begin
        n_chk = 0;
        n_fail = 0;
        zero_outs = 36'h0;
        rst_n = 1'b0;
        drive(21'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Stream of independent instructions, one decode per cycle
        add(mk(4'h0,4'd5,4'd2,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd5,4'd2,8'h00,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h1,4'd6,4'd1,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd6,4'd1,8'h00,8'h00,3'd2,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h2,4'd3,4'd0,8'hFE),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd3,4'd0,8'hFE,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'hB,4'd0,4'd0,8'h55),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h55,3'd0,1'b0,3'd0,2'd3,1'b0));
        add(mk(4'hC,4'd0,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));
        add(mk(4'hC,4'd0,4'd0,8'h00),1'b0,1'b1,1'b0,1'b1,4'd5,1'b1,eo(1'b0,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));
        // LOAD d7 then ADD d1,s7: stall until the cycle after writeback of r7
        add(mk(4'h5,4'd7,4'd0,8'h3C),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd7,4'd0,8'h3C,8'h00,3'd3,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd7,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b0,eo(1'b0,4'd7,4'd0,8'h3C,8'h00,3'd3,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd7,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b0,eo(1'b0,4'd7,4'd0,8'h3C,8'h00,3'd3,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd7,8'h00),1'b1,1'b1,1'b0,1'b1,4'd7,1'b0,eo(1'b0,4'd7,4'd0,8'h3C,8'h00,3'd3,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd7,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd1,4'd7,8'h00,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        // SENDCON held for three back-pressured cycles
        add(mk(4'h6,4'd0,4'd0,8'h0F),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h0F,8'h00,3'd0,1'b0,3'd3,2'd0,1'b0));
        for (int k = 0; k < 3; k++)
            add(mk(4'h8,4'd0,4'd0,8'h00),1'b1,1'b0,1'b0,1'b0,4'd0,1'b0,eo(1'b1,4'd0,4'd0,8'h0F,8'h00,3'd0,1'b0,3'd3,2'd0,1'b0));
        add(mk(4'h8,4'd0,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b1));
        // BEQ held, then flushed while a new instruction is offered
        add(mk(4'h9,4'd2,4'd4,8'h9A),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd2,4'd4,8'h00,8'h9A,3'd4,1'b0,3'd0,2'd1,1'b0));
        add(mk(4'h0,4'd8,4'd9,8'h00),1'b1,1'b0,1'b1,1'b0,4'd0,1'b0,eo(1'b0,4'd2,4'd4,8'h00,8'h9A,3'd4,1'b0,3'd0,2'd1,1'b0));
        // r1 is still pending from the earlier ADD d1: stall until written back
        add(mk(4'h2,4'd1,4'd0,8'h11),1'b1,1'b1,1'b0,1'b0,4'd0,1'b0,eo(1'b0,4'd2,4'd4,8'h00,8'h9A,3'd4,1'b0,3'd0,2'd1,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h11),1'b1,1'b1,1'b0,1'b1,4'd1,1'b0,eo(1'b0,4'd2,4'd4,8'h00,8'h9A,3'd4,1'b0,3'd0,2'd1,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h11),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd1,4'd0,8'h11,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        // Flush of an un-issued ADDI d1 leaves r1 clear
        add(mk(4'h0,4'd9,4'd10,8'h00),1'b1,1'b0,1'b1,1'b0,4'd0,1'b0,eo(1'b0,4'd1,4'd0,8'h11,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h22),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd1,4'd0,8'h22,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        // Flush together with a downstream handshake: r1 becomes pending
        add(mk(4'hC,4'd0,4'd0,8'h00),1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,eo(1'b0,4'd1,4'd0,8'h22,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b0,eo(1'b0,4'd1,4'd0,8'h22,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd0,8'h00),1'b0,1'b1,1'b0,1'b1,4'd1,1'b0,eo(1'b0,4'd1,4'd0,8'h22,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        add(mk(4'h0,4'd1,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd1,4'd0,8'h00,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        // Set and clear of r1 in the same cycle: set wins
        add(mk(4'hC,4'd0,4'd0,8'h00),1'b1,1'b1,1'b0,1'b1,4'd1,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h33),1'b1,1'b1,1'b0,1'b0,4'd0,1'b0,eo(1'b0,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h33),1'b1,1'b1,1'b0,1'b1,4'd1,1'b0,eo(1'b0,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));
        add(mk(4'h2,4'd1,4'd0,8'h33),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd1,4'd0,8'h33,8'h00,3'd1,1'b1,3'd0,2'd0,1'b0));
        // Remaining opcodes
        add(mk(4'h3,4'd0,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd1,2'd0,1'b0));
        add(mk(4'h4,4'd0,4'd0,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd2,2'd0,1'b0));
        add(mk(4'h7,4'd0,4'd2,8'h00),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd2,8'h00,8'h00,3'd0,1'b0,3'd4,2'd0,1'b0));
        add(mk(4'hA,4'd0,4'd0,8'h44),1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,eo(1'b1,4'd0,4'd0,8'h00,8'h44,3'd0,1'b0,3'd0,2'd2,1'b0));

        // Reset state before any clock edge
        #1;
        chk("reset_outs", act_outs(), zero_outs);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].v, vecs[i].ir, vecs[i].fl, vecs[i].wbv, vecs[i].wbd);
            #1;
            chk($sformatf("row%0d_ready", i), {35'h0, o_ready}, {35'h0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_outs", i), act_outs(), vecs[i].outs);
        end

        // Mid-stream asynchronous reset: BEQF held and r1/r3/r6 pending
        @(negedge clk);
        drive(mk(4'h2,4'd3,4'd0,8'h00), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        chk("pre_reset_ready", {35'h0, o_ready}, 36'h0);
        chk("pre_reset_valid", {35'h0, o_valid}, 36'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", act_outs(), zero_outs);
        chk("async_reset_sb_clear", {35'h0, o_ready}, 36'h1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Unused opcode E
        @(negedge clk);
        drive(mk(4'hE,4'd0,4'd0,8'h00), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        chk("opE_ready", {35'h0, o_ready}, 36'h1);
        @(posedge clk);
        #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp_s = eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0) | 36'h1;
`else
        exp_s = eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0);
`endif
        chk("opE_outs", act_outs(), exp_s);
        @(negedge clk);
        drive(mk(4'hC,4'd0,4'd0,8'h00), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("trap_ready", {35'h0, o_ready}, 36'h0);
        exp_s = eo(1'b0,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0) | 36'h1;
`else
        chk("trap_ready", {35'h0, o_ready}, 36'h1);
        exp_s = eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0);
`endif
        @(posedge clk);
        #1;
        chk("trap_hold_outs", act_outs(), exp_s);
        @(negedge clk);
        drive(mk(4'hC,4'd0,4'd0,8'h00), 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        #1;
        chk("flush_ready", {35'h0, o_ready}, 36'h0);
        @(posedge clk);
        #1;
        chk("flush_outs", act_outs(), zero_outs);
        @(negedge clk);
        drive(mk(4'hC,4'd0,4'd0,8'h00), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        chk("post_flush_ready", {35'h0, o_ready}, 36'h1);
        @(posedge clk);
        #1;
        chk("post_flush_outs", act_outs(), eo(1'b1,4'd0,4'd0,8'h00,8'h00,3'd0,1'b0,3'd0,2'd0,1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
